// File: rtl/dds_pkg.sv
// Shared state encoding and error codes for the DDS update sequencer.
package dds_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StWaitBusy = 3'd2,
    StWaitFin  = 3'd3,
    StLoad     = 3'd4,
    StWaitRel  = 3'd5,
    StErr      = 3'd6
  } state_e;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrBusy    = 2'b01;
  localparam logic [1:0] ErrFinish  = 2'b10;
  localparam logic [1:0] ErrRelease = 2'b11;

  function automatic logic is_wait_state(input state_e s);
    return (s == StWaitBusy) || (s == StWaitFin) || (s == StWaitRel);
  endfunction

endpackage

// File: rtl/hs_timeout.sv
// Handshake timeout counter: expires on the TO_CYC-th enabled cycle since the last clear.
module hs_timeout #(
  parameter int unsigned TO_W   = 20,
  parameter int unsigned TO_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [TO_W-1:0] LastCnt = TO_W'(TO_CYC - 1);

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

  assign o_expired = i_enable && (r_cnt == LastCnt);

endmodule

// File: rtl/dds_update_seq.sv
// Sequences one depacketised command across the enabled DDS controllers with
// busy/finish/release handshakes and a per-state timeout.
module dds_update_seq
  import dds_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned TO_W   = 20,
  parameter int unsigned TO_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pkt_ready,
  output logic              o_pkt_load,
  input  logic [NUM_CH-1:0] i_ch_en,
  output logic [NUM_CH-1:0] o_ch_update,
  input  logic [NUM_CH-1:0] i_ch_busy,
  input  logic [NUM_CH-1:0] i_ch_finish,
  output logic              o_err,
  output logic [1:0]        o_err_code,
  output logic [NUM_CH-1:0] o_err_ch,
  output logic [2:0]        o_state_dbg
);

  state_e            r_state, w_state_d;
  logic [NUM_CH-1:0] r_en_q, w_en_q_d;
  logic [NUM_CH-1:0] r_ch_update, w_ch_update_d;
  logic              r_pkt_load, w_pkt_load_d;
  logic              r_err, w_err_d;
  logic [1:0]        r_err_code, w_err_code_d;
  logic [NUM_CH-1:0] r_err_ch, w_err_ch_d;
  logic              w_all_busy, w_all_fin, w_expired;

  // Channels outside the latched enable mask count as already satisfied.
  assign w_all_busy = &(i_ch_busy | ~r_en_q);
  assign w_all_fin  = &(i_ch_finish | ~r_en_q);

  hs_timeout #(
    .TO_W   (TO_W),
    .TO_CYC (TO_CYC)
  ) u_hs_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_state_d != r_state),
    .i_enable  (is_wait_state(r_state)),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_d    = r_state;
    w_en_q_d     = r_en_q;
    w_err_code_d = r_err_code;
    w_err_ch_d   = r_err_ch;
    unique case (r_state)
      StIdle: begin
        if (i_pkt_ready) begin
          w_state_d    = StStart;
          w_err_code_d = ErrNone;
          w_err_ch_d   = '0;
        end
      end
      StStart: begin
        w_en_q_d  = i_ch_en;
        w_state_d = (i_ch_en == '0) ? StLoad : StWaitBusy;
      end
      StWaitBusy: begin
        if (w_all_busy) begin
          w_state_d = StWaitFin;
        end else if (w_expired) begin
          w_state_d    = StErr;
          w_err_code_d = ErrBusy;
          w_err_ch_d   = r_en_q & ~i_ch_busy;
        end
      end
      StWaitFin: begin
        if (w_all_fin) begin
          w_state_d = StLoad;
        end else if (w_expired) begin
          w_state_d    = StErr;
          w_err_code_d = ErrFinish;
          w_err_ch_d   = r_en_q & ~i_ch_finish;
        end
      end
      StLoad: w_state_d = StWaitRel;
      StWaitRel: begin
        if (!i_pkt_ready) begin
          w_state_d = StIdle;
        end else if (w_expired) begin
          w_state_d    = StErr;
          w_err_code_d = ErrRelease;
          w_err_ch_d   = '0;
        end
      end
      // A stuck controller still consumes the command; a stuck depacketiser does not.
      StErr:   w_state_d = (r_err_code == ErrRelease) ? StIdle : StLoad;
      default: w_state_d = StIdle;
    endcase

    w_ch_update_d = (w_state_d == StWaitBusy) ? w_en_q_d : '0;
    w_pkt_load_d  = (w_state_d == StLoad) || (w_state_d == StWaitRel);
    w_err_d       = (w_state_d == StErr);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_en_q      <= '0;
      r_ch_update <= '0;
      r_pkt_load  <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= ErrNone;
      r_err_ch    <= '0;
    end else begin
      r_state     <= w_state_d;
      r_en_q      <= w_en_q_d;
      r_ch_update <= w_ch_update_d;
      r_pkt_load  <= w_pkt_load_d;
      r_err       <= w_err_d;
      r_err_code  <= w_err_code_d;
      r_err_ch    <= w_err_ch_d;
    end
  end

  assign o_pkt_load  = r_pkt_load;
  assign o_ch_update = r_ch_update;
  assign o_err       = r_err;
  assign o_err_code  = r_err_code;
  assign o_err_ch    = r_err_ch;
  assign o_state_dbg = r_state;

endmodule

// File: doc/dds_update_seq.md
DDS_UPDATE_SEQ -- requirements
Module: dds_update_seq

Interface
REQ-001 Parameter NUM_CH, default 2, number of DDS controller channels sequenced, range 1..8.
REQ-002 Parameter TO_W, default 20, width of the handshake timeout counter.
REQ-003 Parameter TO_CYC, default 1000000, clk cycles allowed per wait state before timeout, must be < 2^TO_W.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-low.
REQ-006 pkt_ready  in  1  depacketiser has a valid command held.
REQ-007 pkt_load  out  1  consume command; depacketiser drops pkt_ready in response.
REQ-008 ch_en  in  NUM_CH  per-channel update enable; sampled once per command.
REQ-009 ch_update  out  NUM_CH  update request to each DDS controller.
REQ-010 ch_busy  in  NUM_CH  controller has accepted the update.
REQ-011 ch_finish  in  NUM_CH  controller has completed register programming.
REQ-012 err  out  1  one-cycle pulse on timeout.
REQ-013 err_code  out  2  00 none, 01 busy timeout, 10 finish timeout, 11 ready-release timeout; held until next command.
REQ-014 err_ch  out  NUM_CH  enabled channels still pending at timeout; held with err_code.
REQ-015 state_dbg  out  3  current state encoding for debug probes.

Function
REQ-016 States: IDLE(0), START(1), WAIT_BUSY(2), WAIT_FIN(3), LOAD(4), WAIT_REL(5), ERR(6).
REQ-017 IDLE: on pkt_ready=1 go to START next cycle; clear err_code, err_ch.
REQ-018 START: latch ch_en into en_q; drive ch_update=en_q from next cycle; go to WAIT_BUSY; if ch_en=0 go directly to LOAD with no update asserted.
REQ-019 WAIT_BUSY: exit when (ch_busy | ~en_q) is all ones; then ch_update <= 0 for all channels, go to WAIT_FIN.
REQ-020 ch_update for a channel stays high until REQ-019 exit, even if that channel's busy rose earlier.
REQ-021 WAIT_FIN: exit to LOAD when (ch_finish | ~en_q) is all ones in the same cycle; finish need not be sticky across channels; go to LOAD.
REQ-022 LOAD: pkt_load <= 1, go to WAIT_REL.
REQ-023 WAIT_REL: when pkt_ready=0, pkt_load <= 0, go to IDLE.
REQ-024 Timeout counter clears on every state entry and increments each cycle in WAIT_BUSY, WAIT_FIN, WAIT_REL; reaching TO_CYC enters ERR.
REQ-025 ERR: err=1 for exactly one cycle; err_code per REQ-013; err_ch = en_q & ~ch_busy (or ~ch_finish) at the expiring cycle; ch_update <= 0.
REQ-026 From ERR on busy/finish timeout go to LOAD, so the stale command is discarded; on release timeout go to IDLE with pkt_load=0.
REQ-027 Channel inputs outside en_q are ignored in all states.
REQ-028 ch_en changes after START have no effect on the current command.
REQ-029 Latency: pkt_ready rise to ch_update rise = 2 cycles.

Reset
REQ-030 While rst=0: state=IDLE, pkt_load=0, ch_update=0, err=0, err_code=00, err_ch=0, en_q=0, counter=0.
REQ-031 Reset asserted mid-operation aborts immediately; no pkt_load is issued for the aborted command.

Structure
REQ-032 State encoding and err_code constants live in the shared dds_pkg package.
REQ-033 One sub-module, hs_timeout (clear, enable, expired), implements the counter.

Verification
REQ-034 NUM_CH=2, ch_en=11, busy both at +3, finish both at +10 -> ch_update high for cycles 2..4 after ready, one pkt_load pulse, err never set.
REQ-035 ch_en=01, ch_busy[1]/ch_finish[1] held 0 -> ch_update=01 only, command completes normally.
REQ-036 ch_en=00 -> ch_update stays 0, pkt_load asserted 2 cycles after pkt_ready.
REQ-037 TO_CYC=16, ch_busy[1] never rises -> err pulse, err_code=01, err_ch=10, ch_update drops, pkt_load follows.
REQ-038 finish[0] at +5, finish[1] at +8, never coincident -> remains in WAIT_FIN until timeout, err_code=10, err_ch=11.
REQ-039 rst=0 pulsed in WAIT_FIN -> all outputs at reset values next cycle; no pkt_load.
